// File: rtl/fifo_drain_ctrl.sv
// Write-buffer drain: pops {addr,data} entries from a FIFO and issues each one
// as a memory write with req/ack, retrying on error or timeout and dropping after MAX_RETRY.
module fifo_drain_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int CNTR_W    = 4,
   parameter int TIMEOUT   = 15,
   parameter int MAX_RETRY = 3,
   parameter int RETRY_GAP = 2,
   parameter int ERR_W     = 8
) (
   input  logic                     clk,
   input  logic                     FIFO_clr_n,
   input  logic                     FIFO_reset_n,
   input  logic                     en,
   input  logic [ADDR_W+DATA_W-1:0] fifo_data,
   input  logic [CNTR_W-1:0]        fifo_cnt,
   output logic                     fifo_pop,
   output logic                     mem_req,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic                     mem_ack,
   input  logic                     mem_err,
   output logic                     busy,
   output logic                     drained,
   output logic [ERR_W-1:0]         drop_cnt
);

   localparam int TMAX  = (TIMEOUT > RETRY_GAP) ? TIMEOUT : RETRY_GAP;
   localparam int TMR_W = $clog2(TMAX + 1);
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {IDLE, REQ, BACKOFF} state_t;

   state_t             state, state_nxt;
   logic [TMR_W-1:0]   timer, timer_nxt;
   logic [RTY_W-1:0]   retry_cnt, retry_nxt;
   logic               req_nxt;
   logic               load;
   logic               drop_inc;

   assign fifo_pop = (state == IDLE) && en && (fifo_cnt != '0) && FIFO_reset_n;
   assign busy     = (state != IDLE);
   assign drained  = (state == IDLE) && (fifo_cnt == '0);

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      retry_nxt = retry_cnt;
      req_nxt   = mem_req;
      load      = 1'b0;
      drop_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_pop) begin
               load      = 1'b1;
               req_nxt   = 1'b1;
               retry_nxt = '0;
               timer_nxt = '0;
               state_nxt = REQ;
            end
         end
         REQ: begin
            // A clean ack beats a timeout landing in the same cycle.
            if (mem_ack && !mem_err) begin
               req_nxt   = 1'b0;
               state_nxt = IDLE;
            end else if (mem_ack || (timer == TMR_W'(TIMEOUT - 1))) begin
               req_nxt = 1'b0;
               if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                  retry_nxt = retry_cnt + 1'b1;
                  timer_nxt = '0;
                  state_nxt = BACKOFF;
               end else begin
                  drop_inc  = 1'b1;
                  state_nxt = IDLE;
               end
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         BACKOFF: begin
            if (timer == TMR_W'(RETRY_GAP - 1)) begin
               timer_nxt = '0;
               req_nxt   = 1'b1;
               state_nxt = REQ;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge FIFO_clr_n) begin
      if (!FIFO_clr_n)        state <= IDLE;
      else if (!FIFO_reset_n) state <= IDLE;
      else                    state <= state_nxt;
   end

   // Soft reset abandons the in-flight entry but keeps the drop history.
   always_ff @(posedge clk or negedge FIFO_clr_n) begin
      if (!FIFO_clr_n) begin
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         retry_cnt <= '0;
         timer     <= '0;
         drop_cnt  <= '0;
      end else if (!FIFO_reset_n) begin
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         retry_cnt <= '0;
         timer     <= '0;
      end else begin
         mem_req   <= req_nxt;
         retry_cnt <= retry_nxt;
         timer     <= timer_nxt;
         if (load) begin
            mem_addr  <= fifo_data[ADDR_W+DATA_W-1:DATA_W];
            mem_wdata <= fifo_data[DATA_W-1:0];
         end
         if (drop_inc && (drop_cnt != {ERR_W{1'b1}}))
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_fifo_drain_ctrl;

   localparam int TIMEOUT   = 15;
   localparam int MAX_RETRY = 3;
   localparam int RETRY_GAP = 2;

   logic        clk = 1'b0;
   logic        FIFO_clr_n, FIFO_reset_n, en;
   logic [63:0] fifo_data;
   logic [3:0]  fifo_cnt;
   logic        fifo_pop, mem_req, mem_ack, mem_err, busy, drained;
   logic [31:0] mem_addr, mem_wdata;
   logic [7:0]  drop_cnt;

   fifo_drain_ctrl dut (
      .clk(clk), .FIFO_clr_n(FIFO_clr_n), .FIFO_reset_n(FIFO_reset_n), .en(en),
      .fifo_data(fifo_data), .fifo_cnt(fifo_cnt), .fifo_pop(fifo_pop),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_err(mem_err), .busy(busy), .drained(drained),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // Model: an entry is either absent, in a request window (age counts cycles
   // spent waiting), or sitting out a gap between windows.
   bit          m_busy, m_inreq;
   logic [31:0] m_addr, m_data;
   int          m_age, m_gap, m_tries, m_drops;

   always @(posedge clk or negedge FIFO_clr_n) begin
      if (!FIFO_clr_n) begin
         m_busy <= 0; m_inreq <= 0; m_addr <= 0; m_data <= 0; m_drops <= 0;
      end else if (!FIFO_reset_n) begin
         m_busy <= 0; m_inreq <= 0; m_addr <= 0; m_data <= 0;
      end else if (!m_busy) begin
         if (en && fifo_cnt != 0) begin
            m_addr <= fifo_data[63:32]; m_data <= fifo_data[31:0];
            m_busy <= 1; m_inreq <= 1; m_age <= 0; m_tries <= 0;
         end
      end else if (m_inreq) begin
         if (mem_ack && !mem_err) m_busy <= 0;
         else if (mem_ack || m_age == TIMEOUT - 1) begin
            if (m_tries < MAX_RETRY) begin
               m_tries <= m_tries + 1; m_inreq <= 0; m_gap <= 0;
            end else begin
               m_drops <= m_drops + 1; m_busy <= 0;
            end
         end else m_age <= m_age + 1;
      end else begin
         if (m_gap == RETRY_GAP - 1) begin m_inreq <= 1; m_age <= 0; end
         else m_gap <= m_gap + 1;
      end
   end

   int n_chk = 0, n_pass = 0;
   int cyc, pop_seen, req_seen, gap_seen;
   int pop_at[$];
   bit last_req;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      bit e_req, e_pop;
      int e_drop;
      #1;
      e_req  = m_busy && m_inreq;
      e_pop  = !m_busy && en && (fifo_cnt != 0) && FIFO_reset_n;
      e_drop = (m_drops > 255) ? 255 : m_drops;
      chk("fifo_pop", fifo_pop, e_pop);
      chk("mem_req", mem_req, e_req);
      chk("busy", busy, m_busy);
      chk("drained", drained, !m_busy && fifo_cnt == 0);
      chk("drop_cnt", drop_cnt, e_drop);
      if (e_req) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, m_data);
      end
      if (fifo_pop) begin pop_seen++; pop_at.push_back(cyc); end
      if (mem_req) req_seen++;
      if (busy && !mem_req) gap_seen++;
      last_req = mem_req;
      @(negedge clk);
      cyc++;
   endtask

   task automatic clr_counts();
      cyc = 0; pop_seen = 0; req_seen = 0; gap_seen = 0; pop_at.delete();
   endtask

   initial begin
      int mode;
      FIFO_clr_n = 0; FIFO_reset_n = 1; en = 0; fifo_cnt = 0; fifo_data = 0;
      mem_ack = 0; mem_err = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("clr_req", mem_req, 0);
      chk("clr_busy", busy, 0);
      chk("clr_drained", drained, 1);
      @(negedge clk);
      FIFO_clr_n = 1;

      // Empty FIFO after clear
      en = 1; clr_counts();
      tick();
      chk("idle_pop", fifo_pop, 0);
      chk("idle_drained", drained, 1);
      chk("idle_busy", busy, 0);
      chk("idle_req", mem_req, 0);
      chk("idle_drop", drop_cnt, 0);

      // Single write, ack two cycles after req rises
      clr_counts();
      fifo_data = {32'h1000, 32'hDEAD_BEEF}; fifo_cnt = 1;
      tick();
      fifo_cnt = 0; tick(); tick();
      mem_ack = 1; tick();
      mem_ack = 0; tick();
      chk("wr_pops", pop_seen, 1);
      chk("wr_req_cycles", req_seen, 3);
      chk("wr_addr", mem_addr, 32'h1000);
      chk("wr_data", mem_wdata, 32'hDEAD_BEEF);
      chk("wr_busy", busy, 0);
      chk("wr_drained", drained, 1);

      // Error ack, backoff, clean retry
      clr_counts();
      fifo_data = {32'h2000, 32'h1234_5678}; fifo_cnt = 1;
      tick();
      fifo_cnt = 0; tick();
      mem_ack = 1; mem_err = 1; tick();
      mem_ack = 0; mem_err = 0; tick(); tick(); tick();
      mem_ack = 1; tick();
      mem_ack = 0; tick();
      chk("rt_req_cycles", req_seen, 4);
      chk("rt_gap_cycles", gap_seen, RETRY_GAP);
      chk("rt_addr", mem_addr, 32'h2000);
      chk("rt_data", mem_wdata, 32'h1234_5678);
      chk("rt_drop", drop_cnt, 0);
      chk("rt_busy", busy, 0);

      // No ack at all: four timed-out windows, then drop
      clr_counts();
      fifo_data = {32'h3000, 32'hCAFE_F00D}; fifo_cnt = 1;
      tick();
      fifo_cnt = 0;
      repeat (70) tick();
      chk("to_req_cycles", req_seen, 60);
      chk("to_gap_cycles", gap_seen, 6);
      chk("to_drop", drop_cnt, 1);
      chk("to_busy", busy, 0);

      // Soft reset in the middle of a request
      clr_counts();
      fifo_data = {32'h4000, 32'h0BAD_F00D}; fifo_cnt = 1;
      tick();
      repeat (3) tick();
      FIFO_reset_n = 0; tick();
      chk("sr_req", mem_req, 0);
      chk("sr_busy", busy, 0);
      chk("sr_drop", drop_cnt, 1);
      chk("sr_addr", mem_addr, 0);
      chk("sr_pops_held", pop_seen, 1);
      FIFO_reset_n = 1; tick();
      chk("sr_repop", pop_seen, 2);
      fifo_cnt = 0; tick();
      mem_ack = 1; tick();
      mem_ack = 0; tick();
      chk("sr_done_busy", busy, 0);

      // Back-to-back with a slave that acks one cycle after seeing req
      clr_counts(); last_req = 0; fifo_cnt = 4;
      for (int i = 0; i < 12; i++) begin
         en = (cyc < 7);
         mem_ack = last_req && mem_req;
         fifo_data = {32'h5000 + 32'(i), $urandom};
         tick();
         if (pop_at.size() > 0 && pop_at[pop_at.size()-1] == cyc - 1) fifo_cnt = fifo_cnt - 1;
      end
      mem_ack = 0;
      chk("bb_pops", pop_at.size(), 3);
      if (pop_at.size() == 3) begin
         chk("bb_pop0", pop_at[0], 0);
         chk("bb_pop1", pop_at[1], 3);
         chk("bb_pop2", pop_at[2], 6);
      end
      chk("bb_left", fifo_cnt, 1);
      chk("bb_busy", busy, 0);

      // Randomized traffic
      mode = 1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) mode = $urandom_range(0, 3);
         FIFO_reset_n = ($urandom % 60) != 0;
         en           = ($urandom % 8) != 0;
         fifo_cnt     = (($urandom % 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         fifo_data    = {$urandom, $urandom};
         mem_err      = ($urandom % 3) == 0;
         case (mode)
            0:       mem_ack = !mem_req && ($urandom % 4) == 0;
            1:       mem_ack = ($urandom % 3) == 0;
            2:       mem_ack = mem_req && ($urandom % 12) == 0;
            default: mem_ack = mem_req;
         endcase
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
